uop_sequencer: RTL and testbench

- Sits between the CVA6 commit ports and the single-entry `fsm` converter.
- Collects up to NR_COMMIT_PORTS retiring uops per cycle into an in-order FIFO and presents them one per cycle to `fsm` with a valid/ready handshake.
- Detects FIFO overflow, drops the affected uops, counts them, and sequences a drain-and-resync so the trace encoder sees a clean discontinuity.

---
 rtl/connector_pkg.sv | 18 +
 rtl/uop_fifo_multi.sv | 72 +++++++
 rtl/uop_sequencer.sv | 132 +++++++++++++
 tb/tb_uop_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connector_pkg.sv
// Shared types for the commit-port to trace-converter path.
// Uop bundle, sequencer states and default port count.
package connector_pkg;

  localparam int unsigned NR_COMMIT_PORTS = 2;

  typedef enum logic {
    RUN,
    DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [2:0]  itype;
  } uop_entry_s;

endpackage

// File: rtl/uop_fifo_multi.sv
// N-write / 1-read circular uop buffer.
// Writes land at wptr..wptr+n-1 and are visible next cycle.
module uop_fifo_multi
  import connector_pkg::*;
#(
  parameter  int unsigned NW    = 2,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1,
  localparam int unsigned NWW   = $clog2(NW + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [NWW-1:0]   n_push_i,
  input  uop_entry_s       wdata_i [NW],
  input  logic             pop_i,
  output uop_entry_s       rdata_o,
  output logic [CW-1:0]    count_o,
  output logic [CW-1:0]    free_o
);

  uop_entry_s    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_wr;

  assign n_wr = push_i ? CW'(n_push_i) : '0;

  // pointer and occupancy next-state; clear overrides push and pop
  always_comb begin
    wptr_d  = wptr_q + AW'(n_wr);
    rptr_d  = rptr_q + AW'(pop_i);
    count_d = count_q + n_wr - CW'(pop_i);
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // storage write; slots past the pointer wrap naturally
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      for (int i = 0; i < NW; i++) begin
        if (NWW'(i) < n_push_i) begin
          mem_q[wptr_q + AW'(i)] <= wdata_i[i];
        end
      end
    end
  end

  assign rdata_o = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o = count_q;
  assign free_o  = CW'(DEPTH) - count_q;

endmodule

// File: rtl/uop_sequencer.sv
// Compacts commit-port uops into an in-order FIFO.
// Overflow drops whole groups, counts them and drains to resync.
module uop_sequencer
  import connector_pkg::*;
#(
  parameter  int unsigned NR_COMMIT_PORTS = connector_pkg::NR_COMMIT_PORTS,
  parameter  int unsigned DEPTH           = 8,
  parameter  int unsigned DROP_CNT_W      = 16,
  localparam int unsigned CW              = $clog2(DEPTH) + 1,
  localparam int unsigned PW              = $clog2(NR_COMMIT_PORTS + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  uop_entry_s                 uop_entry_i [NR_COMMIT_PORTS],
  input  logic [NR_COMMIT_PORTS-1:0] uop_valid_i,
  input  logic                       clear_i,
  input  logic                       ready_i,
  output uop_entry_s                 uop_entry_o,
  output logic                       valid_o,
  output logic [CW-1:0]              fill_o,
  output logic                       overflow_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  output logic                       resync_o
);

  logic [PW-1:0]         pos [NR_COMMIT_PORTS];
  logic [PW-1:0]         n_in;
  uop_entry_s            cmp_w [NR_COMMIT_PORTS];
  seq_state_e            state_q, state_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d, drop_sat;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [CW-1:0]         count_w, free_w, space, count_nxt;
  logic                  pop, push, fits;

  // slot index of each valid port = number of valid ports below it
  always_comb begin
    n_in = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      pos[i] = n_in;
      n_in   = n_in + PW'(uop_valid_i[i]);
    end
  end

  // pack valid ports into consecutive slots, oldest first
  always_comb begin
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      cmp_w[k] = '0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (uop_valid_i[i] && pos[i] == PW'(k)) begin
          cmp_w[k] = uop_entry_i[i];
        end
      end
    end
  end

  assign valid_o  = (count_w != '0);
  assign pop      = valid_o & ready_i;
  assign space    = free_w + CW'(pop);
  assign fits     = (CW'(n_in) <= space);
  assign drop_sum = {1'b0, drop_q} + (DROP_CNT_W + 1)'(n_in);
  assign drop_sat = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

  // overflow FSM: RUN accepts whole groups, DRAIN drops until empty
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    push       = 1'b0;
    resync_o   = 1'b0;
    count_nxt  = count_w - CW'(pop);
    unique case (state_q)
      RUN: begin
        if (fits) begin
          push = 1'b1;
        end else begin
          overflow_d = 1'b1;
          drop_d     = drop_sat;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        drop_d = drop_sat;
        if (count_nxt == '0) begin
          state_d  = RUN;
          resync_o = 1'b1;
        end
      end
    endcase
    if (clear_i) begin
      state_d    = RUN;
      overflow_d = 1'b0;
      drop_d     = '0;
      push       = 1'b0;
      resync_o   = 1'b0;
    end
  end

  // FSM state, sticky overflow and drop counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  uop_fifo_multi #(
    .NW    (NR_COMMIT_PORTS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .push_i   (push),
    .n_push_i (n_in),
    .wdata_i  (cmp_w),
    .pop_i    (pop),
    .rdata_o  (uop_entry_o),
    .count_o  (count_w),
    .free_o   (free_w)
  );

  assign fill_o     = count_w;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_uop_sequencer;
  import connector_pkg::*;

  localparam int NP = 2;
  localparam int D  = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  uop_entry_s      e_i [NP];
  logic [NP-1:0]   v_i;
  logic            clr;
  logic            rdy;
  uop_entry_s      e_o;
  logic            valid_o;
  logic [3:0]      fill_o;
  logic            ovf_o;
  logic [DW-1:0]   drop_o;
  logic            resync_o;

  int              total = 0;
  int              bad   = 0;
  logic [31:0]     q[$];

  always #5 clk = ~clk;

  uop_sequencer #(
    .NR_COMMIT_PORTS (NP),
    .DEPTH           (D),
    .DROP_CNT_W      (DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .uop_entry_i (e_i),
    .uop_valid_i (v_i),
    .clear_i     (clr),
    .ready_i     (rdy),
    .uop_entry_o (e_o),
    .valid_o     (valid_o),
    .fill_o      (fill_o),
    .overflow_o  (ovf_o),
    .drop_cnt_o  (drop_o),
    .resync_o    (resync_o)
  );

  function automatic uop_entry_s mk(input logic [31:0] pc);
    uop_entry_s r;
    r.pc    = pc;
    r.insn  = ~pc;
    r.itype = pc[2:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] vv, input logic [31:0] p0,
                       input logic [31:0] p1, input logic r);
    v_i    = vv;
    e_i[0] = mk(p0);
    e_i[1] = mk(p1);
    rdy    = r;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".fill"}, 96'(fill_o), 96'(0));
    chk({tag, ".valid"}, 96'(valid_o), 96'(0));
    chk({tag, ".head"}, 96'(e_o), 96'(0));
    chk({tag, ".ovf"}, 96'(ovf_o), 96'(0));
    chk({tag, ".drop"}, 96'(drop_o), 96'(0));
    chk({tag, ".resync"}, 96'(resync_o), 96'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    #2;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: two ports at once, popped in order
    drive(2'b11, 32'hA0, 32'hB0, 1'b1);
    smp();
    chk("t1.fill0", 96'(fill_o), 96'(0));
    chk("t1.valid0", 96'(valid_o), 96'(0));
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b1);
    smp();
    chk("t1.valid1", 96'(valid_o), 96'(1));
    chk("t1.headA", 96'(e_o), 96'(mk(32'hA0)));
    chk("t1.fill2", 96'(fill_o), 96'(2));
    step();
    smp();
    chk("t1.headB", 96'(e_o), 96'(mk(32'hB0)));
    chk("t1.fill1", 96'(fill_o), 96'(1));
    step();
    smp();
    chk("t1.valid3", 96'(valid_o), 96'(0));
    chk("t1.fill3", 96'(fill_o), 96'(0));
    chk("t1.head0", 96'(e_o), 96'(0));
    step();

    // 2: gap on port0, head held under backpressure
    drive(2'b10, 32'h0, 32'hC0, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("t2.fill", 96'(fill_o), 96'(1));
      chk("t2.headC", 96'(e_o), 96'(mk(32'hC0)));
      step();
    end
    rdy = 1'b1;
    smp();
    chk("t2.popC", 96'(e_o), 96'(mk(32'hC0)));
    step();
    smp();
    chk("t2.empty", 96'(fill_o), 96'(0));
    step();

    // 3: overflow, drain, resync
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h100 + 2 * k, 32'h101 + 2 * k, 1'b0);
      step();
    end
    drive(2'b11, 32'hE0, 32'hE1, 1'b0);
    smp();
    chk("t3.full", 96'(fill_o), 96'(8));
    chk("t3.ovf0", 96'(ovf_o), 96'(0));
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) drive(2'b11, 32'hF0, 32'hF1, 1'b1);
      smp();
      if (k == 0) begin
        chk("t3.ovf1", 96'(ovf_o), 96'(1));
        chk("t3.drop2", 96'(drop_o), 96'(2));
      end
      chk("t3.head", 96'(e_o), 96'(mk(32'h100 + k)));
      chk("t3.fill", 96'(fill_o), 96'(8 - k));
      chk("t3.resync", 96'(resync_o), 96'(k == 7));
      step();
    end
    drive(2'b01, 32'h1A0, 32'h0, 1'b0);
    smp();
    chk("t3.fillz", 96'(fill_o), 96'(0));
    chk("t3.validz", 96'(valid_o), 96'(0));
    chk("t3.resync0", 96'(resync_o), 96'(0));
    chk("t3.drop4", 96'(drop_o), 96'(4));
    chk("t3.sticky", 96'(ovf_o), 96'(1));
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    smp();
    chk("t3.acc", 96'(fill_o), 96'(1));
    chk("t3.accH", 96'(e_o), 96'(mk(32'h1A0)));
    rdy = 1'b1;
    step();
    smp();
    chk("t3.acc0", 96'(fill_o), 96'(0));
    step();

    // 4: full with pop plus one push, pointer wrap
    clr = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    step();
    clr = 1'b0;
    smp();
    chk("t4.clrOvf", 96'(ovf_o), 96'(0));
    chk("t4.clrDrop", 96'(drop_o), 96'(0));
    step();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h200 + 2 * k, 32'h201 + 2 * k, 1'b0);
      q.push_back(32'h200 + 2 * k);
      q.push_back(32'h201 + 2 * k);
      step();
    end
    for (int j = 0; j < 10; j++) begin
      drive(2'b01, 32'h300 + j, 32'h0, 1'b1);
      smp();
      chk("t4.head", 96'(e_o), 96'(mk(q.pop_front())));
      chk("t4.fill", 96'(fill_o), 96'(8));
      chk("t4.ovf", 96'(ovf_o), 96'(0));
      q.push_back(32'h300 + j);
      step();
    end
    drive(2'b00, 32'h0, 32'h0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      smp();
      chk("t4.drain", 96'(e_o), 96'(mk(q.pop_front())));
      step();
    end
    smp();
    chk("t4.empty", 96'(fill_o), 96'(0));
    step();

    // 5: clear in the middle of DRAIN
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h400 + 2 * k, 32'h401 + 2 * k, 1'b0);
      step();
    end
    drive(2'b11, 32'h4A0, 32'h4A1, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b1);
    smp();
    chk("t5.ovf", 96'(ovf_o), 96'(1));
    chk("t5.fill", 96'(fill_o), 96'(8));
    step();
    clr = 1'b1;
    drive(2'b11, 32'h4E0, 32'h4E1, 1'b1);
    smp();
    chk("t5.noRes", 96'(resync_o), 96'(0));
    step();
    clr = 1'b0;
    drive(2'b11, 32'h500, 32'h501, 1'b0);
    smp();
    chk_reset("t5.clr");
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    smp();
    chk("t5.push", 96'(fill_o), 96'(2));
    chk("t5.head", 96'(e_o), 96'(mk(32'h500)));
    step();

    // 6: async reset mid-cycle, counter saturation
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(2'b11, 32'h600, 32'h601, 1'b0);
    step();
    drive(2'b11, 32'h602, 32'h603, 1'b0);
    step();
    drive(2'b01, 32'h604, 32'h0, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    smp();
    chk("t6.fill5", 96'(fill_o), 96'(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6.arst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h700 + 2 * k, 32'h701 + 2 * k, 1'b0);
      step();
    end
    drive(2'b11, 32'h7A0, 32'h7A1, 1'b0);
    step();
    repeat (32766) step();
    smp();
    chk("t6.fffe", 96'(drop_o), 96'(16'hFFFE));
    step();
    smp();
    chk("t6.sat", 96'(drop_o), 96'(16'hFFFF));
    step();
    smp();
    chk("t6.hold", 96'(drop_o), 96'(16'hFFFF));
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      smp();
      chk("t6.resync", 96'(resync_o), 96'(j == 7));
      step();
    end
    smp();
    chk("t6.empty", 96'(fill_o), 96'(0));
    chk("t6.ovf", 96'(ovf_o), 96'(1));
    step();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h800 + 2 * k, 32'h801 + 2 * k, 1'b0);
      step();
    end
    drive(2'b11, 32'h8A0, 32'h8A1, 1'b0);
    step();
    smp();
    chk("t6.ovf2", 96'(ovf_o), 96'(1));
    chk("t6.sat2", 96'(drop_o), 96'(16'hFFFF));
    chk("t6.full2", 96'(fill_o), 96'(8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
